// File: rtl/npu_cfg_pkg.sv
// rtl/npu_cfg_pkg.sv - state encoding, header field positions and defaults for npu_config_loader
// ST_CHK exists only when NPU_CFG_CHECKSUM_EN is defined.
package npu_cfg_pkg;

  localparam int DEF_NUM_PE      = 8;
  localparam int DEF_SCHED_DEPTH = 1024;

  // Schedule header: [15:11] reserved, [10:0] schedule length
  localparam int SCHED_RSVD_LSB  = 11;
  localparam int SCHED_LEN_MSB   = 10;

  // PE header: [15:13] PE index, [12:10] reserved, [9:0] weight count
  localparam int PE_IDX_LSB      = 13;
  localparam int PE_RSVD_MSB     = 12;
  localparam int PE_RSVD_LSB     = 10;
  localparam int PE_WCNT_MSB     = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCHED_HDR = 3'd1,
    ST_SCHED     = 3'd2,
    ST_PE_HDR    = 3'd3,
    ST_PE_WGT    = 3'd4,
`ifdef NPU_CFG_CHECKSUM_EN
    ST_CHK       = 3'd5,
`endif
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } state_t;

endpackage

// File: rtl/npu_cfg_checksum.sv
// rtl/npu_cfg_checksum.sv - running 16-bit XOR of config stream words
// Instantiated by npu_config_loader only when NPU_CFG_CHECKSUM_EN is defined.
module npu_cfg_checksum (
  input  logic        CLK,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] data,
  output logic [15:0] result
);

  always_ff @(posedge CLK) begin
    if (clear) begin
      result <= '0;
    end else if (enable) begin
      result <= result ^ data;
    end
  end

endmodule

// File: rtl/npu_config_loader.sv
// rtl/npu_config_loader.sv - parses the NPU config FIFO stream into schedule and PE weight writes
// Optional trailing XOR check word enabled by NPU_CFG_CHECKSUM_EN.
module npu_config_loader
  import npu_cfg_pkg::*;
#(
  parameter int NUM_PE      = DEF_NUM_PE,
  parameter int SCHED_DEPTH = DEF_SCHED_DEPTH
) (
  input  logic              CLK,
  input  logic              npu_rst,
  input  logic              cfg_fifo_empty,
  input  logic [15:0]       cfg_fifo_dout,
  output logic              cfg_fifo_read_en,
  output logic              npu_sched_write_en,
  output logic [15:0]       npu_sched_din,
  output logic [NUM_PE-1:0] npu_pe_weight_write_en,
  output logic [15:0]       npu_pe_weight_din,
  output logic              npu_config_done,
  output logic              npu_config_err
);

  localparam logic [31:0] SCHED_DEPTH_U = 32'(SCHED_DEPTH);
  localparam logic [2:0]  LAST_PE       = 3'(NUM_PE - 1);

  state_t             state, next_state;
  logic               rd_vld;
  logic [10:0]        sec_len, req_cnt, rcv_cnt;
  logic [2:0]         exp_idx;
  logic               rd_en, done_c, err_c;
  logic               sched_we_q;
  logic [15:0]        sched_din_q;
  logic [NUM_PE-1:0]  pe_we_q;
  logic [15:0]        pe_din_q;

  logic [10:0]        hdr_sched_len;
  logic [9:0]         hdr_wcount;
  logic [2:0]         hdr_pe_idx;
  logic               sched_hdr_ok, pe_hdr_ok, last_word, last_pe;
  logic [NUM_PE-1:0]  pe_onehot;

  assign hdr_sched_len = cfg_fifo_dout[SCHED_LEN_MSB:0];
  assign hdr_wcount    = cfg_fifo_dout[PE_WCNT_MSB:0];
  assign hdr_pe_idx    = cfg_fifo_dout[15:PE_IDX_LSB];
  assign sched_hdr_ok  = (cfg_fifo_dout[15:SCHED_RSVD_LSB] == '0) && (hdr_sched_len != '0) &&
                         ({21'd0, hdr_sched_len} <= SCHED_DEPTH_U);
  assign pe_hdr_ok     = (hdr_pe_idx == exp_idx) && (cfg_fifo_dout[PE_RSVD_MSB:PE_RSVD_LSB] == '0);
  assign last_word     = (rcv_cnt + 11'd1) == sec_len;
  assign last_pe       = exp_idx == LAST_PE;
  assign pe_onehot     = NUM_PE'(1) << exp_idx;

`ifdef NPU_CFG_CHECKSUM_EN
  localparam state_t FINAL_ST = ST_CHK;
  logic [15:0] xor_sum;
  logic        cks_en;

  // The check word itself must not fold into the sum it is compared against
  assign cks_en = rd_vld && (state != ST_CHK);

  npu_cfg_checksum u_checksum (
    .CLK    (CLK),
    .clear  (npu_rst),
    .enable (cks_en),
    .data   (cfg_fifo_dout),
    .result (xor_sum)
  );
`else
  localparam state_t FINAL_ST = ST_DONE;
`endif

  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      next_state = ST_SCHED_HDR;
      ST_SCHED_HDR: if (rd_vld) next_state = sched_hdr_ok ? ST_SCHED : ST_ERR;
      ST_SCHED:     if (rd_vld && last_word) next_state = ST_PE_HDR;
      ST_PE_HDR: begin
        if (rd_vld) begin
          if (!pe_hdr_ok)               next_state = ST_ERR;
          else if (hdr_wcount != '0)    next_state = ST_PE_WGT;
          else if (last_pe)             next_state = FINAL_ST;
        end
      end
      ST_PE_WGT:    if (rd_vld && last_word) next_state = last_pe ? FINAL_ST : ST_PE_HDR;
`ifdef NPU_CFG_CHECKSUM_EN
      ST_CHK:       if (rd_vld) next_state = (cfg_fifo_dout == xor_sum) ? ST_DONE : ST_ERR;
`endif
      default: ;
    endcase
  end

  // Headers are fetched one at a time; payload streams until all words are requested
  always_comb begin
    rd_en  = 1'b0;
    done_c = 1'b0;
    err_c  = 1'b0;
    case (state)
      ST_SCHED_HDR, ST_PE_HDR: rd_en = !cfg_fifo_empty && !rd_vld;
`ifdef NPU_CFG_CHECKSUM_EN
      ST_CHK:                  rd_en = !cfg_fifo_empty && !rd_vld;
`endif
      ST_SCHED, ST_PE_WGT:     rd_en = !cfg_fifo_empty && (req_cnt < sec_len);
      ST_DONE:                 done_c = 1'b1;
      ST_ERR:                  err_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      rd_vld      <= 1'b0;
      sec_len     <= '0;
      req_cnt     <= '0;
      rcv_cnt     <= '0;
      exp_idx     <= '0;
      sched_we_q  <= 1'b0;
      sched_din_q <= '0;
      pe_we_q     <= '0;
      pe_din_q    <= '0;
    end else begin
      rd_vld     <= cfg_fifo_read_en;
      sched_we_q <= 1'b0;
      pe_we_q    <= '0;
      if (cfg_fifo_read_en && (state == ST_SCHED || state == ST_PE_WGT)) begin
        req_cnt <= req_cnt + 11'd1;
      end
      if (rd_vld) begin
        case (state)
          ST_SCHED_HDR: begin
            sec_len <= hdr_sched_len;
            req_cnt <= '0;
            rcv_cnt <= '0;
          end
          ST_SCHED: begin
            sched_we_q  <= 1'b1;
            sched_din_q <= cfg_fifo_dout;
            rcv_cnt     <= last_word ? 11'd0 : rcv_cnt + 11'd1;
            if (last_word) req_cnt <= '0;
          end
          ST_PE_HDR: begin
            sec_len <= {1'b0, hdr_wcount};
            if (hdr_wcount == '0) exp_idx <= exp_idx + 3'd1;
          end
          ST_PE_WGT: begin
            pe_we_q  <= pe_onehot;
            pe_din_q <= cfg_fifo_dout;
            rcv_cnt  <= last_word ? 11'd0 : rcv_cnt + 11'd1;
            if (last_word) begin
              req_cnt <= '0;
              exp_idx <= exp_idx + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Every output is forced low for as long as reset is held, not just from the next edge
  assign cfg_fifo_read_en       = rd_en && !npu_rst;
  assign npu_sched_write_en     = sched_we_q && !npu_rst;
  assign npu_sched_din          = npu_rst ? 16'd0 : sched_din_q;
  assign npu_pe_weight_write_en = pe_we_q & {NUM_PE{!npu_rst}};
  assign npu_pe_weight_din      = npu_rst ? 16'd0 : pe_din_q;
  assign npu_config_done        = done_c && !npu_rst;
  assign npu_config_err         = err_c && !npu_rst;

endmodule

// File: tb/tb_npu_config_loader.sv
// tb/tb_npu_config_loader.sv - randomized self-checking bench for npu_config_loader
// Follows NPU_CFG_CHECKSUM_EN the same way as the design build.
module tb_npu_config_loader;

  localparam int NUM_PE      = 8;
  localparam int SCHED_DEPTH = 1024;

  logic              CLK = 1'b0;
  logic              npu_rst = 1'b1;
  logic              cfg_fifo_empty;
  logic [15:0]       cfg_fifo_dout = 16'd0;
  logic              cfg_fifo_read_en;
  logic              npu_sched_write_en;
  logic [15:0]       npu_sched_din;
  logic [NUM_PE-1:0] npu_pe_weight_write_en;
  logic [15:0]       npu_pe_weight_din;
  logic              npu_config_done;
  logic              npu_config_err;

  always #5 CLK = ~CLK;

  npu_config_loader #(.NUM_PE(NUM_PE), .SCHED_DEPTH(SCHED_DEPTH)) dut (
    .CLK                    (CLK),
    .npu_rst                (npu_rst),
    .cfg_fifo_empty         (cfg_fifo_empty),
    .cfg_fifo_dout          (cfg_fifo_dout),
    .cfg_fifo_read_en       (cfg_fifo_read_en),
    .npu_sched_write_en     (npu_sched_write_en),
    .npu_sched_din          (npu_sched_din),
    .npu_pe_weight_write_en (npu_pe_weight_write_en),
    .npu_pe_weight_din      (npu_pe_weight_din),
    .npu_config_done        (npu_config_done),
    .npu_config_err         (npu_config_err)
  );

  // Config FIFO model: main fills fmem while reset is held, this block owns the read side
  logic [15:0] fmem [0:4095];
  int   flen = 0;
  int   rptr = 0;
  int   load_seq = 0;
  int   load_ack = 0;
  int   stall_mode = 0;
  int   pops_total = 0;
  logic stall_r = 1'b0;

  always @(posedge CLK) begin
    if (load_seq != load_ack) begin
      rptr     <= 0;
      load_ack <= load_seq;
    end else if (cfg_fifo_read_en) begin
      pops_total <= pops_total + 1;
      if (rptr < flen) begin
        cfg_fifo_dout <= fmem[rptr];
        rptr          <= rptr + 1;
      end
    end
    case (stall_mode)
      1:       stall_r <= ~stall_r;
      2:       stall_r <= ($urandom_range(0, 2) == 0);
      3:       stall_r <= 1'b1;
      default: stall_r <= 1'b0;
    endcase
  end

  always_comb cfg_fifo_empty = stall_r || (rptr >= flen);

  // Output monitor
  logic [15:0]       sched_obs[$];
  logic [NUM_PE-1:0] wgt_en_obs[$];
  logic [15:0]       wgt_dat_obs[$];
  int   viol = 0;
  logic rd_d1 = 1'b0;
  logic rd_d2 = 1'b0;

  always @(negedge CLK) begin
    if (npu_sched_write_en) sched_obs.push_back(npu_sched_din);
    if (|npu_pe_weight_write_en) begin
      wgt_en_obs.push_back(npu_pe_weight_write_en);
      wgt_dat_obs.push_back(npu_pe_weight_din);
    end
    viol <= viol
          + int'(npu_sched_write_en && (|npu_pe_weight_write_en))
          + int'((|npu_pe_weight_write_en) && !$onehot(npu_pe_weight_write_en))
          + int'((npu_sched_write_en || (|npu_pe_weight_write_en)) && !rd_d2)
          + int'(cfg_fifo_read_en && cfg_fifo_empty)
          + int'(cfg_fifo_read_en && (npu_config_done || npu_config_err));
    rd_d2 <= rd_d1;
    rd_d1 <= cfg_fifo_read_en;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream construction
  logic [15:0] stim[$];
  int          wcs[NUM_PE];
  int          pe_pos[NUM_PE];

  task automatic build(input int slen);
    logic [15:0] x;
    stim.delete();
    stim.push_back(16'(slen));
    repeat (slen) stim.push_back(16'($urandom));
    for (int p = 0; p < NUM_PE; p++) begin
      pe_pos[p] = stim.size();
      stim.push_back(16'(p * 8192 + wcs[p]));
      repeat (wcs[p]) stim.push_back(16'($urandom));
    end
`ifdef NPU_CFG_CHECKSUM_EN
    x = 16'd0;
    foreach (stim[i]) x ^= stim[i];
    stim.push_back(x);
`endif
  endtask

  // Reference model: walks the stream by the format rules
  logic [15:0]       exp_sched[$];
  logic [NUM_PE-1:0] exp_wen[$];
  logic [15:0]       exp_wdat[$];
  int                exp_pops;
  logic              exp_done, exp_err;

  task automatic model();
    int pos, wi, len, wc;
    logic [15:0] x;
    exp_sched.delete();
    exp_wen.delete();
    exp_wdat.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    x   = 16'd0;
    pos = 1;
    wi  = int'(stim[0]);
    x  ^= stim[0];
    len = wi % 2048;
    if (wi / 2048 != 0 || len == 0 || len > SCHED_DEPTH) begin
      exp_err  = 1'b1;
      exp_pops = pos;
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp_sched.push_back(stim[pos]);
      x ^= stim[pos];
      pos++;
    end
    for (int p = 0; p < NUM_PE; p++) begin
      wi = int'(stim[pos]);
      x ^= stim[pos];
      pos++;
      if (wi / 8192 != p || (wi / 1024) % 8 != 0) begin
        exp_err  = 1'b1;
        exp_pops = pos;
        return;
      end
      wc = wi % 1024;
      for (int j = 0; j < wc; j++) begin
        exp_wen.push_back(NUM_PE'(1) << p);
        exp_wdat.push_back(stim[pos]);
        x ^= stim[pos];
        pos++;
      end
    end
`ifdef NPU_CFG_CHECKSUM_EN
    if (stim[pos] == x) exp_done = 1'b1;
    else                exp_err  = 1'b1;
    pos++;
`else
    exp_done = 1'b1;
`endif
    exp_pops = pos;
  endtask

  task automatic load_stream(input string name, input int mode);
    npu_rst    = 1'b1;
    stall_mode = mode;
    foreach (stim[i]) fmem[i] = stim[i];
    for (int i = 0; i < 3; i++) fmem[stim.size() + i] = 16'($urandom);
    flen = stim.size() + 3;
    load_seq++;
    repeat (3) @(negedge CLK);
    check({name, "_rst_ctl"}, 32'({cfg_fifo_read_en, npu_sched_write_en, npu_pe_weight_write_en,
                                   npu_config_done, npu_config_err}), 32'd0);
    check({name, "_rst_bus"}, {npu_sched_din, npu_pe_weight_din}, 32'd0);
  endtask

  task automatic run_stream(input string name, input int mode);
    int cyc, sb, wb, pb, vb, ns, nw;
    model();
    load_stream(name, mode);
    sb = sched_obs.size();
    wb = wgt_en_obs.size();
    pb = pops_total;
    vb = viol;
    npu_rst = 1'b0;
    cyc = 0;
    while (!(npu_config_done || npu_config_err) && cyc < 10000) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, "_finish_in_time"}, 32'(cyc < 10000), 32'd1);
    repeat (6) @(negedge CLK);
    check({name, "_done"}, 32'(npu_config_done), 32'(exp_done));
    check({name, "_err"}, 32'(npu_config_err), 32'(exp_err));
    check({name, "_pops"}, 32'(pops_total - pb), 32'(exp_pops));
    check({name, "_protocol"}, 32'(viol - vb), 32'd0);
    ns = sched_obs.size() - sb;
    nw = wgt_en_obs.size() - wb;
    check({name, "_sched_cnt"}, 32'(ns), 32'(exp_sched.size()));
    check({name, "_wgt_cnt"}, 32'(nw), 32'(exp_wen.size()));
    for (int i = 0; i < ns && i < exp_sched.size(); i++)
      check($sformatf("%s_sched%0d", name, i), 32'(sched_obs[sb + i]), 32'(exp_sched[i]));
    for (int i = 0; i < nw && i < exp_wen.size(); i++) begin
      check($sformatf("%s_wen%0d", name, i), 32'(wgt_en_obs[wb + i]), 32'(exp_wen[i]));
      check($sformatf("%s_wdat%0d", name, i), 32'(wgt_dat_obs[wb + i]), 32'(exp_wdat[i]));
    end
  endtask

  task automatic reset_abort();
    int cyc, sb, wb;
    foreach (wcs[i]) wcs[i] = 0;
    wcs[0] = 6;
    wcs[3] = 4;
    build(5);
    load_stream("abort", 0);
    wb = wgt_en_obs.size();
    npu_rst = 1'b0;
    cyc = 0;
    while (wgt_en_obs.size() == wb && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    check("abort_reach_wgt", 32'(cyc < 2000), 32'd1);
    npu_rst    = 1'b1;
    stall_mode = 3;
    #1;
    check("abort_outs_during", 32'({cfg_fifo_read_en, npu_sched_write_en, npu_pe_weight_write_en,
                                    npu_config_done, npu_config_err}), 32'd0);
    @(negedge CLK);
    check("abort_outs_next", 32'({cfg_fifo_read_en, npu_sched_write_en, npu_pe_weight_write_en,
                                 npu_config_done, npu_config_err}), 32'd0);
    check("abort_bus_next", {npu_sched_din, npu_pe_weight_din}, 32'd0);
    sb = sched_obs.size();
    wb = wgt_en_obs.size();
    npu_rst = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort_no_strobe", 32'((sched_obs.size() - sb) + (wgt_en_obs.size() - wb)), 32'd0);
    check("abort_flags", 32'({npu_config_done, npu_config_err}), 32'd0);
    run_stream("abort_restream", 0);
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (wcs[i]) wcs[i] = 0;
    build(3);
    run_stream("basic", 0);

    foreach (wcs[i]) wcs[i] = 0;
    wcs[1] = 2;
    build(1);
    run_stream("pe1_two_wgt", 0);

    foreach (wcs[i]) wcs[i] = 0;
    build(3);
    stim[0] = 16'h0000;
    run_stream("hdr_zero", 0);
    stim[0] = 16'h0401;
    run_stream("hdr_over", 0);
    stim[0] = 16'h0803;
    run_stream("hdr_rsvd", 0);

    build(SCHED_DEPTH);
    run_stream("hdr_max", 0);

    build(2);
    stim[pe_pos[1]] = 16'h4000;
    run_stream("pe_idx_wrong", 0);

    build(2);
    stim[pe_pos[4]] = stim[pe_pos[4]] | 16'h0800;
    run_stream("pe_rsvd", 0);

    foreach (wcs[i]) wcs[i] = $urandom_range(0, 5);
    build(12);
    run_stream("empty_toggle", 1);

    reset_abort();

`ifdef NPU_CFG_CHECKSUM_EN
    foreach (wcs[i]) wcs[i] = $urandom_range(0, 4);
    build(7);
    run_stream("cks_good", 2);
    stim[stim.size() - 1] = stim[stim.size() - 1] ^ 16'h0001;
    run_stream("cks_bad", 0);
`endif

    for (int k = 0; k < 12; k++) begin
      foreach (wcs[i]) wcs[i] = $urandom_range(0, 8);
      build($urandom_range(1, 40));
      if (k % 4 == 3) stim[pe_pos[$urandom_range(0, NUM_PE - 1)]] ^= 16'h0400 << $urandom_range(0, 2);
      run_stream($sformatf("rand%0d", k), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
